// File: rtl/uart_tx_arbiter.sv
`timescale 1ns/1ps
// uart_tx_arbiter
//   Shares one byte-wide Uart transmitter among four requesters. A requester
//   wins a round-robin arbitration and then owns the Uart until its message
//   ends. A message ends when a byte flagged LAST has been handed to the Uart,
//   or when the owner stays silent for TIMEOUT cycles. Accepted bytes pass
//   through a single holding register. This register decouples the
//   requester handshake from the Uart handshake.
//
// Ports
//   clk          single clock, rising edge
//   rst          asynchronous active-high reset
//   req_valid    [3:0]  per-requester byte valid
//   req_data     [31:0] per-requester byte, requester i on [8i+7:8i]
//   req_last     [3:0]  per-requester end-of-message flag
//   req_ready    [3:0]  per-requester accept (owner only, at most one bit set)
//   uart_in      [7:0]  byte presented to the Uart (holding register)
//   uart_oe      byte-present strobe; transfers when uart_rdy is also high
//   uart_rdy     Uart ready
//   grant        [3:0]  one-hot current owner, zero when idle
//   timeout_evt  one-cycle pulse when a grant is revoked by inactivity
module uart_tx_arbiter #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req_valid,
  input  logic [31:0] req_data,
  input  logic [3:0]  req_last,
  output logic [3:0]  req_ready,
  output logic [7:0]  uart_in,
  output logic        uart_oe,
  input  logic        uart_rdy,
  output logic [3:0]  grant,
  output logic        timeout_evt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // The counter value whose next starved cycle revokes the grant.
  localparam logic [9:0] CNT_LAST = 10'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [1:0]  ptr;
  logic [1:0]  owner;
  logic [1:0]  pick;
  logic        pick_found;
  logic [7:0]  hold;
  logic        hold_v;
  logic        hold_last;
  logic [9:0]  cnt;

  logic        owner_valid;
  logic        owner_last;
  logic [7:0]  owner_byte;
  logic        accept;
  logic        xfer;
  logic        starve;
  logic        expire;
  logic        finish;

  // Round-robin search beginning at ptr. The index arithmetic is two bits
  // wide, so it wraps from 3 to 0.
  always_comb begin : arbitrate
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    pick       = ptr;
    pick_found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (!pick_found && req_valid[ptr + 2'(k)]) begin
        pick       = ptr + 2'(k);
        pick_found = 1'b1;
      end
    end
  end

  // Only the owner's lane is looked at; other lanes are ignored.
  always_comb begin : owner_mux
    owner_valid = req_valid[owner];
    owner_last  = req_last[owner];
    owner_byte  = req_data[{owner, 3'b000} +: 8];
  end

  // Accept and transfer are mutually exclusive. Ready is the inverse of
  // hold_v, so the peak rate is one byte every two cycles.
  always_comb begin : handshakes
    accept = (state == LOCK) && !hold_v && owner_valid;
    xfer   = hold_v && uart_rdy;
    starve = (state == LOCK) && !hold_v && !owner_valid;
    expire = starve && (cnt == CNT_LAST);
    finish = (state == DRAIN) && xfer && hold_last;
  end

  always_comb begin : fsm_next
    state_nxt = state;
    req_ready = 4'b0000;
    grant     = 4'b0000;
    uart_in   = hold;
    uart_oe   = hold_v;
    unique case (state)
      IDLE: begin
        if (pick_found) state_nxt = LOCK;
      end
      LOCK: begin
        grant            = 4'b0001 << owner;
        req_ready[owner] = !hold_v;
        if (accept && owner_last) state_nxt = DRAIN;
        else if (expire)          state_nxt = IDLE;
      end
      DRAIN: begin
        grant = 4'b0001 << owner;
        if (finish) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin : fsm_reg
    // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values regardless of block order.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin : datapath
    // NOTE: the byte register is reset too, because the Uart must see 8'h00 on uart_in while held in reset, not stale data.
    if (rst) begin
      ptr         <= 2'd0;
      owner       <= 2'd0;
      hold        <= 8'h00;
      hold_v      <= 1'b0;
      hold_last   <= 1'b0;
      cnt         <= 10'd0;
      timeout_evt <= 1'b0;
    end else begin
      timeout_evt <= expire;

      if ((state == IDLE) && pick_found) owner <= pick;

      if (accept) begin
        hold      <= owner_byte;
        hold_v    <= 1'b1;
        hold_last <= owner_last;
      end else if (xfer) begin
        hold_v    <= 1'b0;
        hold_last <= 1'b0;
      end

      // The finishing owner becomes the lowest priority for the next round.
      if (finish || expire) ptr <= owner + 2'd1;

      // Count only starved LOCK cycles. A byte waiting on a stalled Uart
      // holds the count, because starve requires hold_v low.
      if ((state != LOCK) || accept || expire) cnt <= 10'd0;
      else if (starve)                        cnt <= cnt + 10'd1;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
// Bench for uart_tx_arbiter.
// Requester stimulus is held in per-requester byte queues. The reference
// model works at message level: it serves pending messages round-robin from
// its own pointer. A message whose queue runs dry without a LAST byte is
// abandoned, and the model counts one timeout for it. The model's byte
// order goes into a scoreboard. A monitor process checks every Uart
// transfer against that scoreboard.
module tb_uart_tx_arbiter;

  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [7:0]  uart_in;
  logic        uart_oe;
  logic        uart_rdy;
  logic [3:0]  grant;
  logic        timeout_evt;

  uart_tx_arbiter #(.TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .uart_in     (uart_in),
    .uart_oe     (uart_oe),
    .uart_rdy    (uart_rdy),
    .grant       (grant),
    .timeout_evt (timeout_evt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] who;
    logic [7:0] data;
  } xfer_t;

  logic [8:0] drv_q [4][$];   // {last, data} still to be offered by each requester
  logic [8:0] mdl_q [4][$];   // same bytes, consumed by the reference model
  xfer_t      exp_q [$];      // expected Uart transfer order
  int         mptr = 0;
  int         exp_to = 0;
  int         seen_to = 0;
  int         cyc = 0;
  int         last_xfer_cyc = 0;
  int         rdy_mode = 0;   // 0: always ready, 1: random, 2: held low
  logic [1:0] first_owner = 2'd0;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit drv_empty();
    bit e = 1'b1;
    for (int r = 0; r < 4; r++) if (drv_q[r].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic push_byte(input int r, input logic [7:0] d, input logic last);
    drv_q[r].push_back({last, d});
    mdl_q[r].push_back({last, d});
  endtask

  task automatic add_rand_msg(input int r, input int len);
    for (int i = 0; i < len; i++) push_byte(r, 8'($urandom), (i == len - 1));
  endtask

  // Message-level round robin over pending requesters.
  task automatic plan();
    bit         first;
    bit         ended;
    int         g;
    logic [8:0] b;
    first = 1'b1;
    while (1) begin
      g = -1;
      for (int k = 0; k < 4; k++)
        if (g < 0 && mdl_q[(mptr + k) % 4].size() > 0) g = (mptr + k) % 4;
      if (g < 0) break;
      if (first) begin
        first_owner = 2'(g);
        first = 1'b0;
      end
      ended = 1'b0;
      while (!ended && mdl_q[g].size() > 0) begin
        b = mdl_q[g].pop_front();
        exp_q.push_back({2'(g), b[7:0]});
        ended = b[8];
      end
      if (!ended) exp_to++;
      mptr = (g + 1) % 4;
    end
  endtask

  // Called on a negedge with the DUT idle. The driver raises valid after
  // the next rising edge. The grant must then appear exactly one edge later.
  task automatic start_scn(input string name);
    plan();
    @(negedge clk);
    check({name, "_arb_wait"}, {28'h0, grant}, 32'h0);
    @(negedge clk);
    check({name, "_first_grant"}, {28'h0, grant}, {28'h0, 4'b0001 << first_owner});
  endtask

  task automatic wait_done(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      done = (exp_q.size() == 0) && (grant == 4'b0000) && drv_empty();
    end
    check({name, "_done"}, {31'h0, done}, 32'h1);
    check({name, "_timeouts"}, seen_to, exp_to);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Requester and Uart driver: inputs change 1 time unit after each rising edge.
  initial begin
    logic [3:0] acc;
    req_valid = 4'b0;
    req_data  = 32'h0;
    req_last  = 4'b0;
    uart_rdy  = 1'b1;
    forever begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int r = 0; r < 4; r++) begin
        if (acc[r] && drv_q[r].size() > 0) void'(drv_q[r].pop_front());
        if (drv_q[r].size() > 0) begin
          req_valid[r]        = 1'b1;
          req_data[8*r +: 8]  = drv_q[r][0][7:0];
          req_last[r]         = drv_q[r][0][8];
        end else begin
          req_valid[r]        = 1'b0;
          req_data[8*r +: 8]  = 8'($urandom);
          req_last[r]         = 1'($urandom);
        end
      end
      case (rdy_mode)
        1:       uart_rdy = 1'($urandom);
        2:       uart_rdy = 1'b0;
        default: uart_rdy = 1'b1;
      endcase
    end
  end

  // Monitor: structural invariants every cycle, plus a scoreboard pop per transfer.
  initial begin
    xfer_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("onehot_grant_ready",
              {31'h0, $onehot0(grant) && $onehot0(req_ready) && ((req_ready & ~grant) == 4'b0)},
              32'h1);
        if (uart_oe && uart_rdy) begin
          last_xfer_cyc = cyc;
          if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_xfer: got byte %0h from grant %0b, expected no transfer (cycle %0d)",
                     uart_in, grant, cyc);
          end else begin
            e = exp_q.pop_front();
            check("xfer_data", {24'h0, uart_in}, {24'h0, e.data});
            check("xfer_owner", {28'h0, grant}, {28'h0, 4'b0001 << e.who});
          end
        end
        if (timeout_evt) seen_to++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int         bad;
    int         nmsg;
    logic [7:0] held;
    logic [3:0] mask;
    rst = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_uart_oe",     {31'h0, uart_oe},     32'h0);
    check("rst_uart_in",     {24'h0, uart_in},     32'h0);
    check("rst_req_ready",   {28'h0, req_ready},   32'h0);
    check("rst_grant",       {28'h0, grant},       32'h0);
    check("rst_timeout_evt", {31'h0, timeout_evt}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Contention: four one-byte messages, served 0,1,2,3
    for (int r = 0; r < 4; r++) push_byte(r, 8'hA0 + 8'(r), 1'b1);
    start_scn("contention");
    wait_done("contention");

    // Fairness: pointer is back at 0, so requester 1 goes before 3
    push_byte(1, 8'h11, 1'b0);
    push_byte(1, 8'h12, 1'b1);
    push_byte(3, 8'h31, 1'b1);
    start_scn("fairness");
    wait_done("fairness");

    // Timeout: requester 0 sends one non-LAST byte and falls silent
    push_byte(0, 8'h5A, 1'b0);
    push_byte(1, 8'h6B, 1'b1);
    start_scn("timeout");
    for (int i = 0; i < 200 && !timeout_evt; i++) @(negedge clk);
    check("to_seen", {31'h0, timeout_evt}, 32'h1);
    // HOLD empties on the edge that ends the transfer cycle; the pulse
    // follows TO edges later.
    check("to_delay", cyc - last_xfer_cyc, TO + 1);
    check("to_grant_cleared", {28'h0, grant}, 32'h0);
    @(negedge clk);
    check("to_pulse_width", {31'h0, timeout_evt}, 32'h0);
    check("to_next_owner", {28'h0, grant}, 32'h2);
    wait_done("timeout");

    // Single message "Hi" from requester 2
    push_byte(2, 8'h48, 1'b0);
    push_byte(2, 8'h69, 1'b1);
    start_scn("hi");
    wait_done("hi");

    // Pointer is now 3: requester 3 goes before 0
    push_byte(0, 8'h01, 1'b1);
    push_byte(3, 8'h03, 1'b1);
    start_scn("ptr3");
    wait_done("ptr3");

    // Backpressure: Uart stalled 50 cycles with a byte held
    rdy_mode = 2;
    push_byte(1, 8'hC3, 1'b0);
    push_byte(1, 8'h3C, 1'b1);
    start_scn("bp");
    for (int i = 0; i < 20 && !uart_oe; i++) @(negedge clk);
    held = uart_in;
    check("bp_held_byte", {24'h0, held}, 32'hC3);
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (!uart_oe || uart_in !== held || req_ready != 4'b0 || timeout_evt) bad++;
    end
    check("bp_stall_bad_cycles", bad, 0);
    rdy_mode = 0;
    wait_done("bp");

    // Randomized traffic: random requester sets, message counts, lengths, Uart readiness
    for (int s = 0; s < 25; s++) begin
      rdy_mode = $urandom_range(0, 1);
      mask = 4'($urandom_range(1, 15));
      for (int r = 0; r < 4; r++) begin
        if (mask[r]) begin
          nmsg = $urandom_range(1, 3);
          for (int m = 0; m < nmsg; m++) add_rand_msg(r, $urandom_range(1, 5));
        end
      end
      start_scn("random");
      wait_done("random");
    end

    // Reset while DRAIN holds a LAST byte
    rdy_mode = 2;
    push_byte(2, 8'hEE, 1'b1);
    start_scn("rst_drain");
    for (int i = 0; i < 20 && !uart_oe; i++) @(negedge clk);
    check("rst_drain_hold_v", {31'h0, uart_oe}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_oe",    {31'h0, uart_oe}, 32'h0);
    check("rst_async_in",    {24'h0, uart_in}, 32'h0);
    check("rst_async_grant", {28'h0, grant},   32'h0);
    // Reset discards the held byte and the grant.
    exp_q.delete();
    for (int r = 0; r < 4; r++) begin
      drv_q[r].delete();
      mdl_q[r].delete();
    end
    mptr = 0;
    rdy_mode = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    // Pointer restarts at 0: requester 1 before 3
    push_byte(3, 8'h33, 1'b1);
    push_byte(1, 8'h77, 1'b1);
    start_scn("post_rst");
    wait_done("post_rst");

    check("total_timeouts", seen_to, exp_to);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
